// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer driver.
//   state_e        : burst FSM states (tone on / silent gap)
//   NOTES          : number of notes in the melody cycle
//   ms_to_cycles() : converts a millisecond window into clock cycles
package beep_pkg;

  typedef enum logic {
    S_ON  = 1'b0,
    S_GAP = 1'b1
  } state_e;

  localparam int unsigned NOTES = 4;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/beep_gen_tone_div.sv
// Half-period divider producing the square-wave tone phase.
// Ports:
//   clk      in  1  system clock, rising edge
//   rst      in  1  synchronous reset, active-high
//   clr      in  1  holds counter and phase at zero
//   en       in  1  advances the half-period counter
//   half_len in  W  half-period length in cycles (>= 1)
//   phase    out 1  tone phase, registered
module tone_div #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] half_len,
  output logic         phase
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;

  // Count 0..half_len-1, toggle phase on wrap; clr wins over en.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (cnt_q == half_len - W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/beep_gen.sv
// Free-running piezo buzzer driver: square-wave tone for BEEP_MS, silence for
// GAP_MS, repeated forever after reset.
// Ports:
//   clk  in  1  system clock, rising edge
//   rst  in  1  synchronous reset, active-high
//   beep out 1  buzzer drive, registered
// Build option:
//   BEEP_MELODY_EN  when defined, burst n uses half period HALF*(n+1) for
//                   n = 0..NOTES-1 cycling, giving a descending 4-note pattern.
module beep_gen
  import beep_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TONE_HZ = 1_000,
  parameter int unsigned BEEP_MS = 200,
  parameter int unsigned GAP_MS  = 200
) (
  input  logic clk,
  input  logic rst,
  output logic beep
);

  localparam int unsigned HALF    = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned ON_CYC  = ms_to_cycles(CLK_HZ, BEEP_MS);
  localparam int unsigned GAP_CYC = ms_to_cycles(CLK_HZ, GAP_MS);

`ifdef BEEP_MELODY_EN
  localparam int unsigned HALF_MAX = HALF * NOTES;
`else
  localparam int unsigned HALF_MAX = HALF;
`endif

  // Tone width must hold half_len itself, not just half_len-1.
  localparam int unsigned TONE_W  = (HALF_MAX >= 1) ? $clog2(HALF_MAX + 1) : 1;
  localparam int unsigned WIN_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int unsigned WIN_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

  if (HALF < 1 || ON_CYC < 1 || GAP_CYC < 1) begin : g_bad_params
    $error("beep_gen: HALF, ON_CYC and GAP_CYC must all be >= 1");
  end

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               beep_q, beep_d;
  logic               tone_phase;
  logic [TONE_W-1:0]  half_len;

`ifdef BEEP_MELODY_EN
  localparam int unsigned NOTE_W = $clog2(NOTES);

  logic [NOTE_W-1:0] note_q, note_d;

  // Note index steps on each gap-to-burst transition and wraps naturally.
  always_comb begin
    note_d = note_q;
    if (state_q == S_GAP && state_d == S_ON) begin
      note_d = note_q + NOTE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_q <= '0;
    end else begin
      note_q <= note_d;
    end
  end

  assign half_len = TONE_W'(HALF * (32'(note_q) + 32'd1));
`else
  assign half_len = TONE_W'(HALF);
`endif

  // Burst/gap FSM with a shared window counter cleared on every state change.
  always_comb begin
    state_d = state_q;
    win_d   = win_q + WIN_W'(1);
    unique case (state_q)
      S_ON: begin
        if (win_q == WIN_W'(ON_CYC - 1)) begin
          state_d = S_GAP;
          win_d   = '0;
        end
      end
      S_GAP: begin
        if (win_q == WIN_W'(GAP_CYC - 1)) begin
          state_d = S_ON;
          win_d   = '0;
        end
      end
    endcase
    beep_d = (state_q == S_ON) & tone_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ON;
      win_q   <= '0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      beep_q  <= beep_d;
    end
  end

  // Divider is held cleared while heading into or sitting in the gap, so every
  // burst starts with phase low and a zero count.
  tone_div #(
    .W (TONE_W)
  ) u_tone_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_d == S_GAP),
    .en       (state_q == S_ON),
    .half_len (half_len),
    .phase    (tone_phase)
  );

  assign beep = beep_q;

endmodule

// File: tb/tb_beep_gen.sv
// Directed bench for beep_gen: reset, tone frame, periodicity, mid-burst and
// mid-gap reset, truncated half period, and (when built with BEEP_MELODY_EN)
// the 4-note melody cycle.
module tb_beep_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic beep_a;
  logic beep_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // HALF=4, ON_CYC=16, GAP_CYC=8
  beep_gen #(
    .CLK_HZ (8000), .TONE_HZ (1000), .BEEP_MS (2), .GAP_MS (1)
  ) u_a (
    .clk (clk), .rst (rst), .beep (beep_a)
  );

  // HALF=3: ON window ends part-way through a half period
  beep_gen #(
    .CLK_HZ (8000), .TONE_HZ (1333), .BEEP_MS (2), .GAP_MS (1)
  ) u_b (
    .clk (clk), .rst (rst), .beep (beep_b)
  );

  // Expected beep after edges 1..24 following reset release, leftmost first.
  localparam logic [0:23] PAT_H4  = 24'b0000_1111_0000_1111_0000_0000;
  localparam logic [0:23] PAT_H3  = 24'b0001_1100_0111_0001_0000_0000;
  localparam logic [0:23] PAT_H8  = 24'b0000_0000_1111_1111_0000_0000;
  localparam logic [0:23] PAT_H12 = 24'b0000_0000_0000_1111_0000_0000;
  localparam logic [0:23] PAT_H16 = 24'b0000_0000_0000_0000_0000_0000;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (beep_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_a cycle=%0d got=%b exp=0", c, beep_a);
      end
      checks++;
      if (beep_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_b cycle=%0d got=%b exp=0", c, beep_b);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (beep_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_low edge=%0d got=%b exp=0", k, beep_a);
      end
    end
  endtask

  task automatic test_tone();
    logic [0:23] pat;
    pat = PAT_H4;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      checks++;
      if (beep_a !== pat[k]) begin
        failures++;
        $display("FAIL tone edge=%0d got=%b exp=%b", k + 1, beep_a, pat[k]);
      end
    end
  endtask

  task automatic test_truncation();
    logic [0:23] pat;
    pat = PAT_H3;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      checks++;
      if (beep_b !== pat[k]) begin
        failures++;
        $display("FAIL truncation edge=%0d got=%b exp=%b", k + 1, beep_b, pat[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [0:23] pat;
    pat = PAT_H4;
    // Reset while beep is high inside the first burst.
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (beep_a !== 1'b1) begin
      failures++;
      $display("FAIL mid_burst_pre got=%b exp=1", beep_a);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (beep_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_burst_rst got=%b exp=0", beep_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      checks++;
      if (beep_a !== pat[k]) begin
        failures++;
        $display("FAIL mid_burst_restart edge=%0d got=%b exp=%b", k + 1, beep_a, pat[k]);
      end
    end
    // Reset inside the gap: edges 1..24 of this frame were just consumed,
    // so run 20 more to land inside the second frame's gap.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (beep_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_gap_rst got=%b exp=0", beep_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      checks++;
      if (beep_a !== pat[k]) begin
        failures++;
        $display("FAIL mid_gap_restart edge=%0d got=%b exp=%b", k + 1, beep_a, pat[k]);
      end
    end
  endtask

`ifdef BEEP_MELODY_EN
  task automatic test_melody();
    logic [0:23] pats [5];
    logic [0:23] pat;
    pats[0] = PAT_H4;
    pats[1] = PAT_H8;
    pats[2] = PAT_H12;
    pats[3] = PAT_H16;
    pats[4] = PAT_H4;
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      pat = pats[f];
      for (int k = 0; k < 24; k++) begin
        @(posedge clk); #1;
        checks++;
        if (beep_a !== pat[k]) begin
          failures++;
          $display("FAIL melody burst=%0d edge=%0d got=%b exp=%b", f, k + 1, beep_a, pat[k]);
        end
      end
    end
  endtask
`else
  task automatic test_period();
    logic [0:23] pat;
    pat = PAT_H4;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 24; k++) begin
        @(posedge clk); #1;
        checks++;
        if (beep_a !== pat[k]) begin
          failures++;
          $display("FAIL period frame=%0d edge=%0d got=%b exp=%b", f, k + 1, beep_a, pat[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tone();
    test_truncation();
    test_mid_reset();
`ifdef BEEP_MELODY_EN
    test_melody();
`else
    test_period();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
